// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for dmem_ctrl: access size codes, FSM state encoding and
// the lane helpers (load extension, store merge, access legality).
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Little-endian lane select followed by sign or zero extension.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_H:    r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SZ_W:    r = word;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  // Overlays the right-justified store data onto the addressed lane(s).
  function automatic logic [31:0] store_merge(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [1:0]  off,
    input logic [1:0]  size
  );
    logic [31:0] r;
    r = word;
    case (size)
      SZ_B: r[{off, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (off[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      SZ_W:    r = wdata;
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic access_bad(
    input logic [31:0] addr,
    input logic [1:0]  size,
    input logic [29:0] word_lim
  );
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    return bad | (addr[31:2] >= word_lim);
  endfunction

endpackage

// File: rtl/dmem_ctrl_rr_arb2.sv
// Two-input round-robin arbiter: on a tie the input not granted last wins.
// last_grant only moves when the requester is actually accepted (adv_i).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // Grant decode from current requests and the last winner.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // last_grant register; starts at input 1 so input 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (adv_i) begin
      last_q <= gnt_o[1];
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Shares a single-port word memory between two byte-addressed requesters,
// with sub-word stores done as read-modify-write.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_data,
  output logic        p0_rsp_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_data,
  output logic        p1_rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0] WORD_LIM = 30'(MEM_WORDS);

  state_t      state_q;
  logic        own_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [1:0]  rsp_valid_q;
  logic [1:0]  rsp_err_q;
  logic        load_rsp_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [1:0]  gnt_s;
  logic        idle_s;
  logic        accept_s;
  logic        req_sel_s;
  logic        req_we_s;
  logic        req_uns_s;
  logic [31:0] req_addr_s;
  logic [31:0] req_wdata_s;
  logic [1:0]  req_size_s;
  logic        req_bad_s;
  logic [1:0]  req_onehot_s;
  logic [1:0]  own_onehot_s;
  logic [31:0] ld_data_s;
  logic [31:0] merge_s;

  assign idle_s       = (state_q == ST_IDLE);
  assign accept_s     = idle_s & (|gnt_s);
  assign req_sel_s    = gnt_s[1];
  assign req_onehot_s = req_sel_s ? 2'b10 : 2'b01;
  assign own_onehot_s = own_q ? 2'b10 : 2'b01;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({p1_valid, p0_valid}),
    .adv_i (accept_s),
    .gnt_o (gnt_s)
  );

  // Payload of the granted requester.
  always_comb begin
    req_we_s    = 1'b0;
    req_uns_s   = 1'b0;
    req_addr_s  = 32'h00000000;
    req_wdata_s = 32'h00000000;
    req_size_s  = 2'b00;
    if (req_sel_s) begin
      req_we_s    = p1_we;
      req_uns_s   = p1_unsigned;
      req_addr_s  = p1_addr;
      req_wdata_s = p1_wdata;
      req_size_s  = p1_size;
    end else begin
      req_we_s    = p0_we;
      req_uns_s   = p0_unsigned;
      req_addr_s  = p0_addr;
      req_wdata_s = p0_wdata;
      req_size_s  = p0_size;
    end
  end

  assign req_bad_s = access_bad(req_addr_s, req_size_s, WORD_LIM);
  assign ld_data_s = load_extend(mem_rdata, off_q, size_q, uns_q);
  assign merge_s   = store_merge(mem_rdata, wdata_q, off_q, size_q);

  // Transaction FSM; response and memory-write strobes are registered so
  // they coincide with the READ->WAIT / WAIT->WRITE / ERR state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      wdata_q     <= 32'h00000000;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      load_rsp_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h00000000;
      mem_wdata_q <= 32'h00000000;
    end else begin
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      load_rsp_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            own_q   <= req_sel_s;
            we_q    <= req_we_s;
            uns_q   <= req_uns_s;
            size_q  <= req_size_s;
            off_q   <= req_addr_s[1:0];
            wdata_q <= req_wdata_s;
            if (req_bad_s) begin
              state_q     <= ST_ERR;
              rsp_valid_q <= req_onehot_s;
              rsp_err_q   <= req_onehot_s;
            end else begin
              mem_addr_q <= {2'b00, req_addr_s[31:2]};
              if (req_we_s && (req_size_s == SZ_W)) begin
                state_q     <= ST_WRITE;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata_s;
                rsp_valid_q <= req_onehot_s;
              end else begin
                state_q <= ST_READ;
              end
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          state_q <= ST_WAIT;
          if (!we_q) begin
            rsp_valid_q <= own_onehot_s;
            load_rsp_q  <= 1'b1;
          end else begin
            load_rsp_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (we_q) begin
            state_q     <= ST_WRITE;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge_s;
            rsp_valid_q <= own_onehot_s;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WRITE: state_q <= ST_IDLE;
        ST_ERR:   state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign p0_ready     = idle_s & gnt_s[0];
  assign p1_ready     = idle_s & gnt_s[1];
  assign p0_rsp_valid = rsp_valid_q[0];
  assign p1_rsp_valid = rsp_valid_q[1];
  assign p0_rsp_err   = rsp_err_q[0];
  assign p1_rsp_err   = rsp_err_q[1];
  // Load data is only valid in WAIT, so it is steered straight from mem_rdata.
  assign p0_rsp_data  = (load_rsp_q && !own_q) ? ld_data_s : 32'h00000000;
  assign p1_rsp_data  = (load_rsp_q &&  own_q) ? ld_data_s : 32'h00000000;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: drivers push expected responses, a monitor
// pops and compares them whenever a response pulse appears.
module tb_dmem_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        err;
    int          t0;
    int          lat;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid, ready, we, uns, rsp_valid, rsp_err;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rsp_data [2];
  logic [1:0]  size [2];
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:4095];
  logic        pre_en;
  logic [11:0] pre_idx;
  logic [31:0] pre_val;

  int cyc;
  int checks;
  int errors;
  int we_seen;
  int we_exp;
  int acc_log[$];
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_WORDS(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(valid[0]), .p0_ready(ready[0]), .p0_we(we[0]), .p0_addr(addr[0]),
    .p0_wdata(wdata[0]), .p0_size(size[0]), .p0_unsigned(uns[0]),
    .p0_rsp_valid(rsp_valid[0]), .p0_rsp_data(rsp_data[0]), .p0_rsp_err(rsp_err[0]),
    .p1_valid(valid[1]), .p1_ready(ready[1]), .p1_we(we[1]), .p1_addr(addr[1]),
    .p1_wdata(wdata[1]), .p1_size(size[1]), .p1_unsigned(uns[1]),
    .p1_rsp_valid(rsp_valid[1]), .p1_rsp_data(rsp_data[1]), .p1_rsp_err(rsp_err[1]),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // data_mem model: synchronous read, one cycle latency, whole-word write.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[11:0]];
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic issue(input int p, input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] sz, input logic u,
                       input logic [31:0] xd, input logic xe, input int xl,
                       input logic [31:0] xwd, input bit keep);
    exp_t e;
    int n;
    we[p] = w; addr[p] = a; wdata[p] = d; size[p] = sz; uns[p] = u; valid[p] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[p] && n < 100);
    if (!ready[p]) begin
      checks++; errors++;
      $display("FAIL %s_accept: no ready after %0d cycles, expected ready", tag, n);
      valid[p] = 1'b0;
      return;
    end
    e.tag = tag; e.data = xd; e.err = xe; e.t0 = cyc; e.lat = xl;
    e.we = w & ~xe; e.waddr = {2'b00, a[31:2]}; e.wdata = xwd;
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    acc_log.push_back(p);
    if (e.we) we_exp++;
    @(posedge clk); #1;
    if (!keep) valid[p] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size()) > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Response monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_we) we_seen++;
        for (int p = 0; p < 2; p++) begin
          if (rsp_valid[p]) begin
            if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
              checks++; errors++;
              $display("FAIL unexpected_rsp: port %0d pulsed rsp_valid, expected none", p);
            end else begin
              if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
              chk({e.tag, "_data"}, rsp_data[p], e.data);
              chk({e.tag, "_err"}, 32'(rsp_err[p]), 32'(e.err));
              chk({e.tag, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
              chk({e.tag, "_we"}, 32'(mem_we), 32'(e.we));
              if (e.we) begin
                chk({e.tag, "_waddr"}, mem_addr, e.waddr);
                chk({e.tag, "_wdata"}, mem_wdata, e.wdata);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst_n = 1'b0; valid = 2'b00; we = 2'b00; uns = 2'b00; pre_en = 1'b0;
    pre_idx = 12'h000; pre_val = 32'h0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 32'h0; wdata[i] = 32'h0; size[i] = 2'b00;
    end
    preload(12'h010, 32'h8BADF00D);
    preload(12'h020, 32'h11223344);
    preload(12'h021, 32'hA5A55A5A);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rsp_data0", rsp_data[0], 32'h0);
    chk("rst_rsp_data1", rsp_data[1], 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads, sub-word store, readback.
    issue(0, "lb_41",  1'b0, 32'h41, 32'h0,  2'b00, 1'b0, 32'hFFFFFFF0, 1'b0, 2, 32'h0, 1'b0);
    issue(0, "lbu_41", 1'b0, 32'h41, 32'h0,  2'b00, 1'b1, 32'h000000F0, 1'b0, 2, 32'h0, 1'b0);
    issue(0, "lh_42",  1'b0, 32'h42, 32'h0,  2'b01, 1'b0, 32'hFFFF8BAD, 1'b0, 2, 32'h0, 1'b0);
    issue(1, "sb_43",  1'b1, 32'h43, 32'h55, 2'b00, 1'b0, 32'h0, 1'b0, 3, 32'h55ADF00D, 1'b0);
    issue(0, "lw_40",  1'b0, 32'h40, 32'h0,  2'b10, 1'b0, 32'h55ADF00D, 1'b0, 2, 32'h0, 1'b0);
    issue(1, "p1_lw_80", 1'b0, 32'h80, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0, 2, 32'h0, 1'b0);
    drain();

    // Both requesters valid every cycle: grants must alternate starting with P0.
    acc_log.delete();
    fork
      begin
        issue(0, "c_lw_80",  1'b0, 32'h80, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0, 2, 32'h0, 1'b1);
        issue(0, "c_lbu_81", 1'b0, 32'h81, 32'h0, 2'b00, 1'b1, 32'h00000033, 1'b0, 2, 32'h0, 1'b1);
        issue(0, "c_lh_86",  1'b0, 32'h86, 32'h0, 2'b01, 1'b0, 32'hFFFFA5A5, 1'b0, 2, 32'h0, 1'b0);
      end
      begin
        issue(1, "c_lhu_84", 1'b0, 32'h84, 32'h0, 2'b01, 1'b1, 32'h00005A5A, 1'b0, 2, 32'h0, 1'b1);
        issue(1, "c_lb_83",  1'b0, 32'h83, 32'h0, 2'b00, 1'b0, 32'h00000011, 1'b0, 2, 32'h0, 1'b1);
        issue(1, "c_lw_84",  1'b0, 32'h84, 32'h0, 2'b10, 1'b0, 32'hA5A55A5A, 1'b0, 2, 32'h0, 1'b0);
      end
    join
    drain();
    chk("grant_count", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < acc_log.size(); i++)
      chk($sformatf("grant_order_%0d", i), 32'(acc_log[i]), 32'(i % 2));

    // Illegal accesses: error at T1, no memory write.
    issue(0, "err_lw_42",   1'b0, 32'h42,   32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1'b0);
    issue(0, "err_lh_41",   1'b0, 32'h41,   32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1'b0);
    issue(0, "err_sz11",    1'b0, 32'h40,   32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1'b0);
    issue(0, "err_lw_4000", 1'b0, 32'h4000, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1'b0);
    issue(1, "err_sw_4000", 1'b1, 32'h4000, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b1, 1, 32'h0, 1'b0);

    // Full-word and half-word stores with readback.
    issue(0, "sw_40",   1'b1, 32'h40, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 1, 32'hDEADBEEF, 1'b0);
    issue(1, "sh_42",   1'b1, 32'h42, 32'hCAFE1234, 2'b01, 1'b0, 32'h0, 1'b0, 3, 32'h1234BEEF, 1'b0);
    issue(0, "lhu_42",  1'b0, 32'h42, 32'h0, 2'b01, 1'b1, 32'h00001234, 1'b0, 2, 32'h0, 1'b0);
    issue(1, "lw_40b",  1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h1234BEEF, 1'b0, 2, 32'h0, 1'b0);
    drain();

    // Reset while a sub-word store sits in WAIT: no write, no response.
    preload(12'h010, 32'h8BADF00D);
    we[1] = 1'b1; addr[1] = 32'h43; wdata[1] = 32'h55; size[1] = 2'b00; uns[1] = 1'b0;
    valid[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[1] && n < 100);
    chk("rst_sb_accept", 32'(ready[1]), 32'd1);
    @(posedge clk); #1;
    valid[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we[0] = 1'b0; addr[0] = 32'h40; size[0] = 2'b10; uns[0] = 1'b0; valid[0] = 1'b1;
    #1;
    chk("idle_after_rst_ready", 32'(ready[0]), 32'd1);
    valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_kept", mem[16], 32'h8BADF00D);
    issue(0, "lw_40_after_rst", 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h8BADF00D, 1'b0, 2, 32'h0, 1'b0);
    drain();
    chk("mem_we_pulses", 32'(we_seen), 32'(we_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
